// File: rtl/gw2a_ddr_rdalign_pkg.sv
// Shared definitions for the GW2A DDR read-data alignment block.
package gw2a_ddr_rdalign_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_CAPTURE, ST_CHECK, ST_DONE, ST_FAIL
  } state_t;

  // bit i is the i-th bit out on the wire: 1,0,0,1,1,1,0,1
  localparam logic [7:0] TRAIN_PAT = 8'hB9;
  localparam int CAP_LEN = 8;
  localparam int OUT_LAT = 4;
endpackage

// File: rtl/gw2a_ddr_lane_align.sv
// One DDR lane: half-cycle history, training-pattern offset search and
// variable-delay realignment of the Q0/Q1 pair.
module gw2a_ddr_lane_align
  import gw2a_ddr_rdalign_pkg::*;
(
  input  logic       PCLK,
  input  logic       RESETN,
  input  logic       in_q0,
  input  logic       in_q1,
  input  logic       snap,
  input  logic [2:0] k_sel,
  input  logic       out_en,
  output logic [2:0] k_res,
  output logic       k_ok,
  output logic       out_q0,
  output logic       out_q1
);
  logic [15:0] hist;
  logic [7:0]  hit;
  logic [2:0]  k_low;
  logic [8:0]  win;
  logic [3:0]  i0, i1;

  always_ff @(posedge PCLK or negedge RESETN)
    if (!RESETN) hist <= '0;
    else         hist <= {hist[13:0], in_q0, in_q1};

  // When snap is high, hist[15-p] holds half-cycle position p of the burst
  always_comb begin
    hit = '1;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++)
        if (hist[15-k-i] != TRAIN_PAT[i]) hit[k] = 1'b0;
    k_low = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (hit[k]) k_low = 3'(k);
  end

  always_ff @(posedge PCLK or negedge RESETN)
    if (!RESETN) begin
      k_res <= '0;
      k_ok  <= 1'b0;
    end else if (snap) begin
      k_res <= k_low;
      k_ok  <= |hit;
    end

  // win[m] is m half-cycles older than the current in_q0; k=7 needs the live bit
  assign win    = {hist[7:0], in_q0};
  assign i0     = 4'd8 - {1'b0, k_sel};
  assign i1     = 4'd7 - {1'b0, k_sel};
  assign out_q0 = out_en & win[i0];
  assign out_q1 = out_en & win[i1];
endmodule

// File: rtl/gw2a_ddr_rdalign.sv
// DDR read calibration: finds each lane's arrival offset from repeated
// training bursts, then delivers realigned data at a fixed latency.
module gw2a_ddr_rdalign
  import gw2a_ddr_rdalign_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PASSES  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               PCLK,
  input  logic               RESETN,
  input  logic               calib_req,
  input  logic               rd_en,
  input  logic [WIDTH-1:0]   in_q0,
  input  logic [WIDTH-1:0]   in_q1,
  output logic               calib_busy,
  output logic               calib_done,
  output logic               calib_fail,
  output logic [3*WIDTH-1:0] lane_offset,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_q0,
  output logic [WIDTH-1:0]   out_q1
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(PASSES + 1);

  state_t                state, state_nxt;
  logic [TW-1:0]         tmo_cnt;
  logic [PW-1:0]         pass_cnt;
  logic [2:0]            cap_cnt;
  logic                  rd_en_d;
  logic [OUT_LAT:1]      vld_pipe;
  logic [WIDTH-1:0][2:0] k_res, cand, offs;
  logic [WIDTH-1:0]      k_ok;
  logic                  snap, cand_ld, pass_inc, off_ld;

  assign snap = (state == ST_CAPTURE) && (cap_cnt == 3'(CAP_LEN - 1));

  always_comb begin
    state_nxt = state;
    cand_ld   = 1'b0;
    pass_inc  = 1'b0;
    off_ld    = 1'b0;
    case (state)
      ST_WAIT:
        if (rd_en && !rd_en_d)                    state_nxt = ST_CAPTURE;
        else if (tmo_cnt == TW'(TIMEOUT - 1))     state_nxt = ST_FAIL;
      ST_CAPTURE:
        if (cap_cnt == 3'(CAP_LEN - 1))           state_nxt = ST_CHECK;
      ST_CHECK:
        if (!(&k_ok) || (pass_cnt != '0 && k_res != cand)) state_nxt = ST_FAIL;
        else begin
          pass_inc = 1'b1;
          cand_ld  = (pass_cnt == '0);
          if (pass_cnt == PW'(PASSES - 1)) begin
            state_nxt = ST_DONE;
            off_ld    = 1'b1;
          end else state_nxt = ST_WAIT;
        end
      default: ;
    endcase
    // a request from any state restarts, dropping whatever was in flight
    if (calib_req) begin
      state_nxt = ST_WAIT;
      cand_ld   = 1'b0;
      pass_inc  = 1'b0;
      off_ld    = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge RESETN)
    if (!RESETN) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      pass_cnt <= '0;
      cap_cnt  <= '0;
      rd_en_d  <= 1'b0;
      vld_pipe <= '0;
      cand     <= '0;
      offs     <= '0;
    end else begin
      state    <= state_nxt;
      rd_en_d  <= rd_en;
      vld_pipe <= {vld_pipe[OUT_LAT-1:1], rd_en};
      tmo_cnt  <= (state == ST_WAIT && state_nxt == ST_WAIT && !calib_req) ?
                  tmo_cnt + 1'b1 : '0;
      cap_cnt  <= (state == ST_CAPTURE && state_nxt == ST_CAPTURE) ?
                  cap_cnt + 1'b1 : '0;
      if (calib_req)     pass_cnt <= '0;
      else if (pass_inc) pass_cnt <= pass_cnt + 1'b1;
      if (cand_ld) cand <= k_res;
      if (off_ld)  offs <= k_res;
    end

  assign calib_busy  = (state == ST_WAIT) || (state == ST_CAPTURE) || (state == ST_CHECK);
  assign calib_done  = (state == ST_DONE);
  assign calib_fail  = (state == ST_FAIL);
  assign lane_offset = offs;
  assign out_valid   = vld_pipe[OUT_LAT] & calib_done;

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    gw2a_ddr_lane_align u_lane (
      .PCLK   (PCLK),
      .RESETN (RESETN),
      .in_q0  (in_q0[n]),
      .in_q1  (in_q1[n]),
      .snap   (snap),
      .k_sel  (offs[n]),
      .out_en (out_valid),
      .k_res  (k_res[n]),
      .k_ok   (k_ok[n]),
      .out_q0 (out_q0[n]),
      .out_q1 (out_q1[n])
    );
  end
endmodule

// File: tb/tb_gw2a_ddr_rdalign.sv
// Directed bench: calibration scenarios checked inline, aligned data checked
// by a queue-based monitor.
module tb_gw2a_ddr_rdalign;
  localparam logic [7:0] TRAIN = 8'hB9;  // 1,0,0,1,1,1,0,1 with bit0 first
  localparam logic [7:0] DATA  = 8'hA5;

  logic        PCLK = 1'b0, RESETN = 1'b0, calib_req = 1'b0, rd_en = 1'b0;
  logic [7:0]  in_q0 = '0, in_q1 = '0;
  logic        calib_busy, calib_done, calib_fail, out_valid;
  logic [23:0] lane_offset;
  logic [7:0]  out_q0, out_q1;

  int          checks = 0, errors = 0;
  int          offs [8];
  logic [7:0]  kill = '0;
  logic [15:0] strm [8];
  logic [15:0] exp_q [$];

  gw2a_ddr_rdalign dut (
    .PCLK(PCLK), .RESETN(RESETN), .calib_req(calib_req), .rd_en(rd_en),
    .in_q0(in_q0), .in_q1(in_q1), .calib_busy(calib_busy), .calib_done(calib_done),
    .calib_fail(calib_fail), .lane_offset(lane_offset), .out_valid(out_valid),
    .out_q0(out_q0), .out_q1(out_q1)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // monitor: every valid beat must match the next queued expectation
  always @(negedge PCLK) begin
    if (RESETN && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid got q0=%h q1=%h", out_q0, out_q1);
      end else check("aligned_data", {16'h0, out_q0, out_q1}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic idle();
    @(posedge PCLK); #1;
    rd_en = 1'b0; in_q0 = '0; in_q1 = '0;
  endtask

  task automatic build(input logic [7:0] pat);
    for (int n = 0; n < 8; n++) begin
      strm[n] = '0;
      if (!kill[n])
        for (int i = 0; i < 8; i++) strm[n][offs[n]+i] = pat[i];
    end
  endtask

  task automatic drive_cyc(input int c);
    @(posedge PCLK); #1;
    rd_en = (c < 4);
    for (int n = 0; n < 8; n++) begin
      in_q0[n] = strm[n][2*c];
      in_q1[n] = strm[n][2*c+1];
    end
  endtask

  task automatic burst(input logic [7:0] pat);
    build(pat);
    for (int c = 0; c < 8; c++) drive_cyc(c);
    for (int c = 0; c < 4; c++) idle();
  endtask

  task automatic calib();
    @(posedge PCLK); #1 calib_req = 1'b1;
    @(posedge PCLK); #1 calib_req = 1'b0;
  endtask

  // 0xA5 bit0-first: beats (q0,q1) = (1,0) (1,0) (0,1) (0,1) on every lane
  task automatic push_a5();
    exp_q.push_back({8'hFF, 8'h00});
    exp_q.push_back({8'hFF, 8'h00});
    exp_q.push_back({8'h00, 8'hFF});
    exp_q.push_back({8'h00, 8'hFF});
  endtask

  task automatic set_offs(input int mode);
    for (int n = 0; n < 8; n++) offs[n] = (mode == 0) ? 0 : (mode == 1) ? n : 7 - n;
  endtask

  initial begin
    set_offs(0);
    #12;
    check("rst_busy", {31'h0, calib_busy}, 0);
    check("rst_done", {31'h0, calib_done}, 0);
    check("rst_fail", {31'h0, calib_fail}, 0);
    check("rst_outs", {7'h0, out_valid, out_q0, out_q1}, 0);
    check("rst_offset", {8'h0, lane_offset}, 0);
    @(posedge PCLK); #1 RESETN = 1'b1;

    // scenario 1: all lanes aligned
    calib();
    for (int p = 0; p < 4; p++) burst(TRAIN);
    check("s1_done", {31'h0, calib_done}, 1);
    check("s1_busy", {31'h0, calib_busy}, 0);
    check("s1_offset", {8'h0, lane_offset}, 0);
    push_a5();
    burst(DATA);

    // scenario 2: lane n offset n half-cycles
    set_offs(1);
    calib();
    for (int p = 0; p < 3; p++) burst(TRAIN);
    check("s2_busy_mid", {30'h0, calib_busy, calib_done}, 2);
    burst(TRAIN);
    check("s2_done", {31'h0, calib_done}, 1);
    check("s2_offset", {8'h0, lane_offset}, 32'hFAC688);
    push_a5();
    burst(DATA);

    // scenario 3: lane 3 moves on the third pass
    offs[3] = 5;
    calib();
    burst(TRAIN); burst(TRAIN);
    check("s3_nofail_yet", {30'h0, calib_busy, calib_fail}, 2);
    offs[3] = 2;
    burst(TRAIN);
    check("s3_fail", {30'h0, calib_fail, calib_done}, 2);
    check("s3_offset_kept", {8'h0, lane_offset}, 32'hFAC688);

    // scenario 4: no burst -> timeout
    @(posedge PCLK); #1 calib_req = 1'b1;
    @(posedge PCLK); #1 calib_req = 1'b0;
    check("s4_fail_cleared", {31'h0, calib_fail}, 0);
    repeat (254) @(posedge PCLK);
    #1 check("s4_before_tmo", {30'h0, calib_busy, calib_fail}, 2);
    @(posedge PCLK); #1 check("s4_at_tmo", {30'h0, calib_busy, calib_fail}, 1);

    // scenario 5: lane 0 stuck low
    set_offs(0);
    kill = 8'h01;
    calib();
    burst(TRAIN);
    check("s5_fail", {31'h0, calib_fail}, 1);
    check("s5_offset_kept", {8'h0, lane_offset}, 32'hFAC688);
    kill = '0;

    // scenario 6: reset in the middle of a capture
    calib();
    build(TRAIN);
    for (int c = 0; c < 4; c++) drive_cyc(c);
    #2 RESETN = 1'b0;
    #1;
    check("s6_rst_status", {29'h0, calib_busy, calib_done, calib_fail}, 0);
    check("s6_rst_outs", {7'h0, out_valid, out_q0, out_q1}, 0);
    check("s6_rst_offset", {8'h0, lane_offset}, 0);
    idle(); idle();
    RESETN = 1'b1;
    set_offs(2);
    calib();
    for (int p = 0; p < 4; p++) burst(TRAIN);
    check("s6_done", {30'h0, calib_done, calib_busy}, 2);
    check("s6_offset", {8'h0, lane_offset}, 32'h053977);
    push_a5();
    burst(DATA);

    repeat (4) idle();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
